// File: rtl/eth_mac_rx_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : eth_mac_rx_filter
// Description : Ethernet receive destination-address filter. Buffers the
//               6-byte DA, decides accept/drop, replays the DA and then
//               passes the remainder of accepted frames through a single
//               output register. Extracts source MAC / EtherType and keeps
//               accept/drop frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mac_rx_filter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // receive byte stream from the MAC
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    // filtered frame stream
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    // filter configuration
    input  logic [47:0]      cfg_mac_addr,
    input  logic             cfg_promisc,
    input  logic             cfg_bcast_en,
    input  logic             cfg_mcast_en,
    // extracted header fields
    output logic [47:0]      hdr_src_mac,
    output logic [15:0]      hdr_ethertype,
    output logic             hdr_valid,
    // frame counters
    output logic [CNT_W-1:0] rx_accept_count,
    output logic [CNT_W-1:0] rx_drop_count
);

    localparam logic [47:0]      c_BCAST_ADDR   = 48'hFFFF_FFFF_FFFF;
    localparam logic [2:0]       c_DA_LAST_IDX  = 3'd5;
    localparam logic [3:0]       c_POS_SA_FIRST = 4'd6;
    localparam logic [3:0]       c_POS_SA_LAST  = 4'd11;
    localparam logic [3:0]       c_POS_TYPE_LO  = 4'd13;
    localparam logic [3:0]       c_POS_DONE     = 4'd14;
    localparam logic [CNT_W-1:0] c_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_REPLAY = 2'd1,
        ST_PASS   = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [2:0]       r_idx;          // DA byte index while collecting
    logic [7:0]       r_da [0:5];     // destination address buffer
    logic [2:0]       r_rep_idx;      // DA byte being replayed
    logic             r_rep_wait;     // one idle cycle before the replay starts
    logic [3:0]       r_pos;          // frame byte position in ST_PASS (6..14, sticks at 14)

    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    logic [47:0]      r_hdr_src;
    logic [15:0]      r_hdr_type;
    logic             r_hdr_valid;

    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_out_free;
    logic             w_in_ready;
    logic [47:0]      w_da;
    logic             w_da_bcast;
    logic             w_da_accept;
    logic             w_addr_done;
    logic             w_drop_inc;
    logic             w_acc_inc;
    logic             w_rep_load;
    logic             w_pass_load;

    // Output register may take a new byte when empty or being drained.
    assign w_out_free  = !r_out_valid || m_axis_tready;

    // Full DA on the deciding cycle: five buffered bytes plus the live one.
    assign w_da        = {r_da[0], r_da[1], r_da[2], r_da[3], r_da[4], s_axis_tdata};
    assign w_da_bcast  = (w_da == c_BCAST_ADDR);
    assign w_da_accept = cfg_promisc
                       || (w_da == cfg_mac_addr)
                       || (w_da_bcast && cfg_bcast_en)
                       || (w_da[40] && !w_da_bcast && cfg_mcast_en);
    assign w_addr_done = (r_idx == c_DA_LAST_IDX);

    // Next-state decode, input ready and per-cycle event strobes.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_drop_inc   = 1'b0;
        w_acc_inc    = 1'b0;
        w_rep_load   = 1'b0;
        w_pass_load  = 1'b0;
        case (r_state)
            ST_ADDR: begin
                w_in_ready = 1'b1;
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        // frame ended within (or exactly at) the DA: runt
                        w_drop_inc = 1'b1;
                    end else if (w_addr_done) begin
                        if (w_da_accept) begin
                            w_next_state = ST_REPLAY;
                        end else begin
                            w_next_state = ST_DROP;
                            w_drop_inc   = 1'b1;
                        end
                    end
                end
            end
            ST_REPLAY: begin
                if (!r_rep_wait && w_out_free) begin
                    w_rep_load = 1'b1;
                    if (r_rep_idx == c_DA_LAST_IDX) begin
                        w_next_state = ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                w_in_ready = w_out_free;
                if (s_axis_tvalid && w_out_free) begin
                    w_pass_load = 1'b1;
                    if (s_axis_tlast) begin
                        w_acc_inc    = 1'b1;
                        w_next_state = ST_ADDR;
                    end
                end
            end
            ST_DROP: begin
                w_in_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_next_state = ST_ADDR;
                end
            end
            default: begin
                w_next_state = ST_ADDR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ADDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Collect destination-address bytes; any tlast or the decision restarts the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                r_da[i] <= 8'd0;
            end
        end else if (r_state == ST_ADDR && s_axis_tvalid) begin
            r_da[r_idx] <= s_axis_tdata;
            if (s_axis_tlast || w_addr_done) begin
                r_idx <= 3'd0;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Replay sequencing: arm on the accept decision, then step through the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_idx  <= 3'd0;
            r_rep_wait <= 1'b0;
        end else if (r_state == ST_ADDR && w_next_state == ST_REPLAY) begin
            r_rep_idx  <= 3'd0;
            r_rep_wait <= 1'b1;
        end else if (r_state == ST_REPLAY) begin
            r_rep_wait <= 1'b0;
            if (w_rep_load) begin
                r_rep_idx <= r_rep_idx + 3'd1;
            end
        end
    end

    // Output register: loaded from the DA buffer or the live stream, cleared on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_rep_load) begin
            r_out_data  <= r_da[r_rep_idx];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
        end else if (w_pass_load) begin
            r_out_data  <= s_axis_tdata;
            r_out_valid <= 1'b1;
            r_out_last  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Header extraction: shift bytes 6..11 into SA and 12..13 into EtherType.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos       <= 4'd0;
            r_hdr_src   <= 48'd0;
            r_hdr_type  <= 16'd0;
            r_hdr_valid <= 1'b0;
        end else begin
            r_hdr_valid <= w_pass_load && !s_axis_tlast && (r_pos == c_POS_TYPE_LO);
            if (w_rep_load && r_rep_idx == c_DA_LAST_IDX) begin
                r_pos <= c_POS_SA_FIRST;
            end else if (w_pass_load && r_pos != c_POS_DONE) begin
                r_pos <= r_pos + 4'd1;
            end
            if (w_pass_load) begin
                if (r_pos <= c_POS_SA_LAST) begin
                    r_hdr_src <= {r_hdr_src[39:0], s_axis_tdata};
                end else if (r_pos <= c_POS_TYPE_LO) begin
                    r_hdr_type <= {r_hdr_type[7:0], s_axis_tdata};
                end
            end
        end
    end

    // Frame counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt  <= {CNT_W{1'b0}};
            r_drop_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_acc_inc) begin
                r_acc_cnt <= r_acc_cnt + c_CNT_ONE;
            end
            if (w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
            end
        end
    end

    assign s_axis_tready   = w_in_ready;
    assign m_axis_tdata    = r_out_data;
    assign m_axis_tvalid   = r_out_valid;
    assign m_axis_tlast    = r_out_last;
    assign hdr_src_mac     = r_hdr_src;
    assign hdr_ethertype   = r_hdr_type;
    assign hdr_valid       = r_hdr_valid;
    assign rx_accept_count = r_acc_cnt;
    assign rx_drop_count   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_mac_rx_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_mac_rx_filter
// Description : Self-checking bench for eth_mac_rx_filter. A frame-level
//               model predicts forwarded bytes, header events and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_mac_rx_filter;

    localparam int CNT_W = 4;   // small so the random run wraps the counters
    localparam logic [47:0] OWN_MAC = 48'h0200_0000_0001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       s_axis_tdata = 8'd0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tlast = 1'b0;
    logic             s_axis_tready;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready = 1'b1;
    logic [47:0]      cfg_mac_addr = OWN_MAC;
    logic             cfg_promisc = 1'b0;
    logic             cfg_bcast_en = 1'b0;
    logic             cfg_mcast_en = 1'b0;
    logic [47:0]      hdr_src_mac;
    logic [15:0]      hdr_ethertype;
    logic             hdr_valid;
    logic [CNT_W-1:0] rx_accept_count;
    logic [CNT_W-1:0] rx_drop_count;

    eth_mac_rx_filter #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .cfg_mac_addr    (cfg_mac_addr),
        .cfg_promisc     (cfg_promisc),
        .cfg_bcast_en    (cfg_bcast_en),
        .cfg_mcast_en    (cfg_mcast_en),
        .hdr_src_mac     (hdr_src_mac),
        .hdr_ethertype   (hdr_ethertype),
        .hdr_valid       (hdr_valid),
        .rx_accept_count (rx_accept_count),
        .rx_drop_count   (rx_drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: toggle every cycle, 2: random
    int bp_mode = 0;
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  frame_q [$];
    logic [8:0]  exp_q [$];      // {tlast, tdata}
    logic [63:0] exp_hdr_q [$];  // {src_mac, ethertype}
    int          exp_acc = 0;
    int          exp_drop = 0;
    int          rise_cyc = -1;
    int          acc6_cyc = 0;

    // Scoreboard: checks every output handshake, hold stability and header pulses.
    task automatic monitor();
        logic       p_v = 1'b0;
        logic       p_r = 1'b0;
        logic       p_l = 1'b0;
        logic [7:0] p_d = 8'd0;
        logic [8:0] e;
        logic [63:0] eh;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_v = 1'b0;
                p_r = 1'b0;
            end else begin
                if (p_v && !p_r) begin
                    vectors++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_d || m_axis_tlast !== p_l) begin
                        miscompares++;
                        $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, p_d, p_l);
                    end
                end
                if (m_axis_tvalid === 1'b1 && !p_v && rise_cyc < 0) rise_cyc = cyc;
                if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL out_byte: got unexpected d=%h l=%b, required no output",
                                 m_axis_tdata, m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_axis_tlast, m_axis_tdata} !== e) begin
                            miscompares++;
                            $display("FAIL out_byte: got d=%h l=%b, required d=%h l=%b",
                                     m_axis_tdata, m_axis_tlast, e[7:0], e[8]);
                        end
                    end
                end
                if (hdr_valid === 1'b1) begin
                    vectors++;
                    if (exp_hdr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL hdr: got unexpected pulse sa=%h type=%h, required none",
                                 hdr_src_mac, hdr_ethertype);
                    end else begin
                        eh = exp_hdr_q.pop_front();
                        if ({hdr_src_mac, hdr_ethertype} !== eh) begin
                            miscompares++;
                            $display("FAIL hdr: got sa=%h type=%h, required sa=%h type=%h",
                                     hdr_src_mac, hdr_ethertype, eh[63:16], eh[15:0]);
                        end
                    end
                end
                p_v = m_axis_tvalid;
                p_r = m_axis_tready;
                p_d = m_axis_tdata;
                p_l = m_axis_tlast;
            end
        end
    endtask

    // Frame-level filter rule applied with the configuration of the deciding byte.
    task automatic model_frame();
        logic [47:0] da;
        logic        bc;
        logic        acc;
        int          len;
        len = frame_q.size();
        if (len <= 6) begin
            exp_drop++;
            return;
        end
        da  = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
        bc  = (da == 48'hFFFF_FFFF_FFFF);
        acc = cfg_promisc || (da == cfg_mac_addr) || (bc && cfg_bcast_en) ||
              (frame_q[0][0] && !bc && cfg_mcast_en);
        if (!acc) begin
            exp_drop++;
            return;
        end
        exp_acc++;
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), frame_q[i]});
        if (len >= 15)
            exp_hdr_q.push_back({frame_q[6], frame_q[7], frame_q[8], frame_q[9], frame_q[10],
                                 frame_q[11], frame_q[12], frame_q[13]});
    endtask

    task automatic build_frame(input logic [47:0] da, input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) frame_q.push_back(da[47 - 8 * i -: 8]);
            else       frame_q.push_back(8'($urandom));
        end
    endtask

    // Present one byte and hold it until the DUT takes it; returns the accepting cycle.
    task automatic drive_byte(input logic [7:0] d, input logic l, output int acc_cyc);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        do begin
            @(negedge clk);
            n++;
        end while (s_axis_tready !== 1'b1 && n < 300);
        vectors++;
        if (s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_timeout: got tready=%b after %0d cycles, required 1", s_axis_tready, n);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic send_frame(input int gap, input int chg_at);
        int len;
        int c;
        len = frame_q.size();
        for (int i = 0; i < len; i++) begin
            if (i == chg_at) begin
                cfg_promisc  = 1'($urandom);
                cfg_bcast_en = 1'($urandom);
                cfg_mcast_en = 1'($urandom);
            end
            if (i == ((len < 6) ? len - 1 : 5)) model_frame();
            drive_byte(frame_q[i], (i == len - 1), c);
            if (i == 5) acc6_cyc = c;
        end
        if (gap > 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_hdr_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tready: got %b, required 1", s_axis_tready);
        end
        vectors++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b l=%b d=%h, required all 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        vectors++;
        if ({hdr_valid, hdr_src_mac, hdr_ethertype} !== 65'd0) begin
            miscompares++;
            $display("FAIL reset_hdr: got v=%b sa=%h type=%h, required all 0", hdr_valid, hdr_src_mac, hdr_ethertype);
        end
        vectors++;
        if (rx_accept_count !== {CNT_W{1'b0}} || rx_drop_count !== {CNT_W{1'b0}}) begin
            miscompares++;
            $display("FAIL reset_cnt: got acc=%0d drop=%0d, required 0/0", rx_accept_count, rx_drop_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_unicast();
        bp_mode = 0;
        build_frame(OWN_MAC, 64);
        frame_q[12] = 8'h08;
        frame_q[13] = 8'h00;
        rise_cyc = -1;
        send_frame(3, -1);
        wait_drain();
        vectors++;
        if (rise_cyc != acc6_cyc + 2) begin
            miscompares++;
            $display("FAIL first_valid_latency: got %0d edges, required 2", rise_cyc - acc6_cyc);
        end
        vectors++;
        if (exp_q.size() != 0 || exp_hdr_q.size() != 0) begin
            miscompares++;
            $display("FAIL unicast_drain: got %0d bytes/%0d hdr missing, required 0/0", exp_q.size(), exp_hdr_q.size());
        end
        vectors++;
        if (rx_accept_count !== 4'd1 || rx_drop_count !== 4'd0) begin
            miscompares++;
            $display("FAIL unicast_cnt: got acc=%0d drop=%0d, required 1/0", rx_accept_count, rx_drop_count);
        end
    endtask

    task automatic test_broadcast();
        bp_mode = 0;
        cfg_bcast_en = 1'b0;
        build_frame(48'hFFFF_FFFF_FFFF, 64);
        rise_cyc = -1;
        send_frame(3, -1);
        wait_drain();
        vectors++;
        if (rise_cyc != -1) begin
            miscompares++;
            $display("FAIL bcast_blocked: got tvalid at cycle %0d, required no tvalid", rise_cyc);
        end
        vectors++;
        if (rx_drop_count !== CNT_W'(exp_drop)) begin
            miscompares++;
            $display("FAIL bcast_drop_cnt: got %0d, required %0d", rx_drop_count, CNT_W'(exp_drop));
        end
        cfg_bcast_en = 1'b1;
        build_frame(48'hFFFF_FFFF_FFFF, 64);
        send_frame(3, -1);
        wait_drain();
        cfg_bcast_en = 1'b0;
        vectors++;
        if (exp_q.size() != 0 || rx_accept_count !== CNT_W'(exp_acc)) begin
            miscompares++;
            $display("FAIL bcast_pass: got %0d bytes missing acc=%0d, required 0 acc=%0d",
                     exp_q.size(), rx_accept_count, CNT_W'(exp_acc));
        end
    endtask

    task automatic test_promisc_runt();
        int lens [6] = '{40, 4, 6, 10, 14, 15};
        bp_mode = 0;
        cfg_promisc = 1'b1;
        for (int k = 0; k < 6; k++) begin
            build_frame(48'h0A12_3456_789A, lens[k]);
            send_frame(2, -1);
        end
        cfg_promisc = 1'b0;
        build_frame(48'hFFFF_FFFF_FFFF, 3);
        send_frame(0, -1);
        build_frame(OWN_MAC, 20);           // directly after a runt: index must be clear
        send_frame(2, -1);
        cfg_mcast_en = 1'b1;
        build_frame(48'h0100_5E00_0001, 30);
        send_frame(2, -1);
        build_frame(48'hFFFF_FFFF_FFFF, 30); // broadcast is not multicast
        send_frame(2, -1);
        cfg_mcast_en = 1'b0;
        wait_drain();
        vectors++;
        if (exp_q.size() != 0 || exp_hdr_q.size() != 0) begin
            miscompares++;
            $display("FAIL promisc_drain: got %0d bytes/%0d hdr missing, required 0/0", exp_q.size(), exp_hdr_q.size());
        end
        vectors++;
        if (rx_accept_count !== CNT_W'(exp_acc) || rx_drop_count !== CNT_W'(exp_drop)) begin
            miscompares++;
            $display("FAIL promisc_cnt: got acc=%0d drop=%0d, required %0d/%0d",
                     rx_accept_count, rx_drop_count, CNT_W'(exp_acc), CNT_W'(exp_drop));
        end
    endtask

    task automatic test_backpressure();
        bp_mode = 1;
        build_frame(OWN_MAC, 100);
        send_frame(2, -1);
        wait_drain();
        bp_mode = 0;
        vectors++;
        if (exp_q.size() != 0 || rx_accept_count !== CNT_W'(exp_acc)) begin
            miscompares++;
            $display("FAIL bp_frame: got %0d bytes missing acc=%0d, required 0 acc=%0d",
                     exp_q.size(), rx_accept_count, CNT_W'(exp_acc));
        end
    endtask

    task automatic test_reset_midframe();
        int c;
        bp_mode = 0;
        build_frame(OWN_MAC, 64);
        for (int i = 0; i < 30; i++) begin
            if (i == 5) model_frame();
            drive_byte(frame_q[i], 1'b0, c);
        end
        #2;
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        vectors++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 10'd0 || s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_out: got v=%b l=%b d=%h rdy=%b, required 0/0/00/1",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready);
        end
        vectors++;
        if (rx_accept_count !== {CNT_W{1'b0}} || rx_drop_count !== {CNT_W{1'b0}} ||
            {hdr_valid, hdr_src_mac, hdr_ethertype} !== 65'd0) begin
            miscompares++;
            $display("FAIL async_reset_state: got acc=%0d drop=%0d sa=%h, required 0/0/0",
                     rx_accept_count, rx_drop_count, hdr_src_mac);
        end
        exp_q.delete();
        exp_hdr_q.delete();
        exp_acc  = 0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        build_frame(OWN_MAC, 64);
        send_frame(2, -1);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0 || rx_accept_count !== 4'd1 || rx_drop_count !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset_frame: got %0d missing acc=%0d drop=%0d, required 0/1/0",
                     exp_q.size(), rx_accept_count, rx_drop_count);
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        bp_mode = 0;
        acc0 = exp_acc;
        build_frame(OWN_MAC, 64);
        send_frame(0, -1);
        build_frame(OWN_MAC, 64);
        send_frame(2, -1);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0 || exp_acc != acc0 + 2 || rx_accept_count !== CNT_W'(exp_acc)) begin
            miscompares++;
            $display("FAIL b2b: got %0d missing acc=%0d, required 0 acc=%0d",
                     exp_q.size(), rx_accept_count, CNT_W'(acc0 + 2));
        end
    endtask

    task automatic test_random();
        logic [47:0] da;
        int          len;
        bp_mode = 2;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 4))
                0:       da = OWN_MAC;
                1:       da = 48'hFFFF_FFFF_FFFF;
                2:       da = {8'($urandom) | 8'h01, 40'($urandom), 8'($urandom)};
                3:       da = {8'($urandom) & 8'hFE, 40'($urandom), 8'($urandom)};
                default: da = OWN_MAC ^ (48'h01 << (8 * $urandom_range(0, 5)));
            endcase
            len = (f % 8 == 0) ? $urandom_range(1, 16) : $urandom_range(7, 80);
            build_frame(da, len);
            send_frame($urandom_range(0, 2), $urandom_range(0, len + 5));
        end
        s_axis_tvalid = 1'b0;
        wait_drain();
        bp_mode = 0;
        vectors++;
        if (exp_q.size() != 0 || exp_hdr_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain: got %0d bytes/%0d hdr missing, required 0/0", exp_q.size(), exp_hdr_q.size());
        end
        vectors++;
        if (rx_accept_count !== CNT_W'(exp_acc) || rx_drop_count !== CNT_W'(exp_drop)) begin
            miscompares++;
            $display("FAIL random_cnt: got acc=%0d drop=%0d, required %0d/%0d",
                     rx_accept_count, rx_drop_count, CNT_W'(exp_acc), CNT_W'(exp_drop));
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_unicast();
        test_broadcast();
        test_promisc_runt();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
